// File: rtl/msi_irq_arbiter.sv
// Multi-source MSI interrupt arbiter: edge-latched pending bits, round-robin
// selection onto the allocated MSI vector range, request/grant with hold-off.
module msi_irq_arbiter #(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               overrun_clr,
   input  logic               msi_enable,
   input  logic [2:0]         msi_vector_width,
   input  logic               intx_msi_grant,
   output logic               intx_msi_request,
   output logic [4:0]         msi_vector_num,
   output logic [NUM_SRC-1:0] irq_pending,
   output logic [NUM_SRC-1:0] irq_overrun,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] src_q, src_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] overrun_q, overrun_d;
   logic [4:0]         sel_q, sel_d;
   logic [4:0]         last_q, last_d;
   logic [4:0]         vec_q, vec_d;
   logic               req_q, req_d;
   logic [15:0]        cnt_q, cnt_d;

   logic [NUM_SRC-1:0] src_edge;
   logic [NUM_SRC-1:0] grant_clr;
   logic [31:0]        elig32;
   logic               found;
   logic [4:0]         pick;
   int unsigned        idx;
   logic [2:0]         width_eff;
   logic [4:0]         vec_max;
   logic [4:0]         pick_vec;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      elig32 = 32'(pending_q & ~irq_mask);
      found  = 1'b0;
      pick   = last_q;
      idx    = 0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = (32'(last_q) + 1 + i) % NUM_SRC;
         if (!found && elig32[idx[4:0]]) begin
            found = 1'b1;
            pick  = idx[4:0];
         end
      end
   end

   always_comb begin
      width_eff = (msi_vector_width > 3'd5) ? 3'd5 : msi_vector_width;
      vec_max   = 5'((6'd1 << width_eff) - 6'd1);
      pick_vec  = (pick <= vec_max) ? pick : vec_max;
   end

   always_comb begin
      src_edge  = irq_src & ~src_q;
      grant_clr = '0;
      if (state_q == S_REQ && intx_msi_grant) begin
         grant_clr = NUM_SRC'(32'd1 << sel_q);
      end
      src_d     = irq_src;
      // A same-cycle edge on the granted source keeps it pending without overrun.
      pending_d = (pending_q & ~grant_clr) | src_edge;
      overrun_d = (overrun_clr ? '0 : overrun_q) | (src_edge & pending_q & ~grant_clr);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      vec_d   = vec_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (msi_enable && found) begin
               sel_d   = pick;
               vec_d   = pick_vec;
               req_d   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (intx_msi_grant) begin
               req_d   = 1'b0;
               last_d  = sel_q;
               cnt_d   = 16'(HOLDOFF);
               state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q <= 16'd1) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         sel_q     <= '0;
         last_q    <= 5'(NUM_SRC - 1);
         vec_q     <= '0;
         req_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         vec_q     <= vec_d;
         req_q     <= req_d;
         cnt_q     <= cnt_d;
      end
   end

   assign intx_msi_request = req_q;
   assign msi_vector_num   = vec_q;
   assign irq_pending      = pending_q;
   assign irq_overrun      = overrun_q;
   assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Scoreboard bench for msi_irq_arbiter: directed stimulus pushes expected
// vectors; a monitor pops them as requests appear.
module tb_msi_irq_arbiter;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] src;
   logic [N-1:0] mask;
   logic         oclr;
   logic         en;
   logic [2:0]   width;
   logic         grant;
   logic         req;
   logic [4:0]   vec;
   logic [N-1:0] pend;
   logic [N-1:0] ovr;
   logic         busy;

   msi_irq_arbiter #(.NUM_SRC(N), .HOLDOFF(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .irq_src          (src),
      .irq_mask         (mask),
      .overrun_clr      (oclr),
      .msi_enable       (en),
      .msi_vector_width (width),
      .intx_msi_grant   (grant),
      .intx_msi_request (req),
      .msi_vector_num   (vec),
      .irq_pending      (pend),
      .irq_overrun      (ovr),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int vec;
      int gap;   // cycles from previous grant to request rise; -1 = unchecked
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   cyc = 0;
   int   g_cyc = 0;
   logic req_seen = 1'b0;
   int   cur_vec = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req && grant) g_cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (req && !req_seen) begin
         if (q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_request: got vector %0d, expected no request (cycle %0d)", vec, cyc);
            cur_vec = int'(vec);
         end else begin
            mon_e = q.pop_front();
            chk("req_vector", int'(vec), mon_e.vec);
            cur_vec = mon_e.vec;
            if (mon_e.gap >= 0) chk("req_gap", cyc - g_cyc, mon_e.gap);
         end
      end else if (req && req_seen) begin
         chk("vector_stable", int'(vec), cur_vec);
      end
      req_seen = req;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [N-1:0] m);
      src = src | m;
      tick(1);
      src = src & ~m;
   endtask

   task automatic wait_req();
      int k = 0;
      while (!req && k < 60) begin
         tick(1);
         k++;
      end
      if (!req) chk("wait_req_timeout", 0, 1);
   endtask

   task automatic grant_after(input int d);
      wait_req();
      tick(d);
      grant = 1'b1;
      tick(1);
      grant = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || req) && k < 100) begin
         tick(1);
         k++;
      end
      if (busy || req) chk("wait_idle_timeout", 0, 1);
      tick(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; src = '0; mask = '0; oclr = 1'b0; en = 1'b0; width = 3'd3; grant = 1'b0;
      tick(3);
      chk("rst_req", int'(req), 0);
      chk("rst_vec", int'(vec), 0);
      chk("rst_pend", int'(pend), 0);
      chk("rst_ovr", int'(ovr), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      en = 1'b1;
      tick(1);

      // single source
      q.push_back('{2, -1});
      pulse(8'h04);
      chk("t1_pend2", int'(pend[2]), 1);
      chk("t1_req_early", int'(req), 0);
      tick(1);
      chk("t1_req", int'(req), 1);
      grant_after(5);
      chk("t1_req_low", int'(req), 0);
      chk("t1_pend_clr", int'(pend[2]), 0);
      chk("t1_busy_start", int'(busy), 1);
      tick(15);
      chk("t1_busy_end", int'(busy), 1);
      tick(1);
      chk("t1_busy_off", int'(busy), 0);
      wait_idle();

      // round-robin from reset
      do_reset();
      q.push_back('{0, -1});
      q.push_back('{3, 17});
      q.push_back('{5, 17});
      pulse(8'h29);
      grant_after(2);
      grant_after(2);
      grant_after(2);
      wait_idle();

      // vector clamp
      width = 3'd1;
      q.push_back('{1, -1});
      pulse(8'h40);
      grant_after(1);
      wait_idle();
      width = 3'd6;
      q.push_back('{7, -1});
      pulse(8'h80);
      grant_after(1);
      wait_idle();

      // mask and enable
      mask = 8'h02;
      pulse(8'h02);
      tick(4);
      chk("t4_masked_pend", int'(pend[1]), 1);
      chk("t4_masked_req", int'(req), 0);
      q.push_back('{1, -1});
      mask = '0;
      grant_after(1);
      wait_idle();
      en = 1'b0;
      pulse(8'h08);
      tick(4);
      chk("t4_dis_req", int'(req), 0);
      chk("t4_dis_pend", int'(pend[3]), 1);
      q.push_back('{3, -1});
      en = 1'b1;
      wait_req();
      en = 1'b0;
      tick(3);
      chk("t4_held_req", int'(req), 1);
      grant = 1'b1;
      tick(1);
      grant = 1'b0;
      chk("t4_held_drop", int'(req), 0);
      en = 1'b1;
      wait_idle();

      // overrun and clear
      q.push_back('{4, -1});
      pulse(8'h10);
      wait_req();
      pulse(8'h10);
      chk("t5_ovr_set", int'(ovr[4]), 1);
      grant_after(2);
      chk("t5_req_low", int'(req), 0);
      chk("t5_pend_clr", int'(pend[4]), 0);
      wait_idle();
      tick(5);
      chk("t5_ovr_sticky", int'(ovr[4]), 1);
      oclr = 1'b1;
      tick(1);
      oclr = 1'b0;
      chk("t5_ovr_clr", int'(ovr), 0);
      q.push_back('{4, -1});
      q.push_back('{4, 17});
      pulse(8'h10);
      wait_req();
      tick(2);
      grant = 1'b1;
      src[4] = 1'b1;
      tick(1);
      grant = 1'b0;
      src = '0;
      chk("t5_grant_edge_req", int'(req), 0);
      chk("t5_grant_edge_pend", int'(pend[4]), 1);
      chk("t5_grant_edge_ovr", int'(ovr[4]), 0);
      grant_after(1);
      chk("t5_second_clr", int'(pend[4]), 0);
      wait_idle();

      // reset mid-request
      q.push_back('{0, -1});
      pulse(8'h01);
      wait_req();
      rst = 1'b1;
      tick(1);
      chk("t6_req", int'(req), 0);
      chk("t6_vec", int'(vec), 0);
      chk("t6_pend", int'(pend), 0);
      chk("t6_busy", int'(busy), 0);
      rst = 1'b0;
      tick(25);
      chk("t6_no_req", int'(req), 0);

      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
